// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants and the shared coordinate type.
package vga_timing_pkg;
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    typedef logic [9:0] coord_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster position, sync decodes and frame ticks broadcast to the renderers.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;
    coord_t      DrawX;
    coord_t      DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        blank_d;
    logic        hs_d;
    logic        vs_d;
    logic        frame_start;
    logic        vblank_start;
    logic [15:0] frame_count;
    modport master (output DrawX, DrawY, blank, hs, vs, blank_d, hs_d, vs_d, frame_start, vblank_start, frame_count);
    modport slave  (input  DrawX, DrawY, blank, hs, vs, blank_d, hs_d, vs_d, frame_start, vblank_start, frame_count);
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: async-reset shift register; DEPTH=0 collapses to a wire.
module vga_delay_line #(
    parameter int                 WIDTH     = 3,
    parameter int                 DEPTH     = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;
    end else begin : g_reg
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= {DEPTH{RESET_VAL}};
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end
        assign q_o = stage_q[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters, sync/blank decodes, latency-matched sync and frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int PIPE_DELAY = 2
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_params
        $error("vga_timing_gen: raster totals must be <= 1024 and PIPE_DELAY within 0..7");
    end
    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);
    coord_t      hc_q, hc_d, vc_q, vc_d;
    logic [15:0] fc_q, fc_d;
    logic        h_wrap, v_wrap, blank, hs, vs;
    logic [2:0]  dl_q;
    always_comb begin
        h_wrap = hc_q == H_LAST;
        v_wrap = vc_q == V_LAST;
        hc_d   = h_wrap ? '0 : hc_q + 10'd1;
        vc_d   = h_wrap ? (v_wrap ? '0 : vc_q + 10'd1) : vc_q;
        fc_d   = (h_wrap && v_wrap) ? fc_q + 16'd1 : fc_q;
        blank  = (hc_q < H_VIS) && (vc_q < V_VIS);
        hs     = !((hc_q >= HS_START) && (hc_q < HS_END));
        vs     = !((vc_q >= VS_START) && (vc_q < VS_END));
    end
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc_q <= '0;
            vc_q <= '0;
            fc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
            fc_q <= fc_d;
        end
    end
    // Idle pattern {blank=0, hs=1, vs=1} keeps the pins deasserted until real samples arrive.
    vga_delay_line #(.WIDTH(3), .DEPTH(PIPE_DELAY), .RESET_VAL(3'b011)) u_dl (
        .clk (vga_clk),
        .rst (reset),
        .d_i ({blank, hs, vs}),
        .q_o (dl_q)
    );
    assign vga.DrawX        = hc_q;
    assign vga.DrawY        = vc_q;
    assign vga.blank        = blank;
    assign vga.hs           = hs;
    assign vga.vs           = vs;
    assign vga.blank_d      = dl_q[2];
    assign vga.hs_d         = dl_q[1];
    assign vga.vs_d         = dl_q[0];
    assign vga.frame_start  = (hc_q == '0) && (vc_q == '0);
    assign vga.vblank_start = (hc_q == '0) && (vc_q == V_VIS);
    assign vga.frame_count  = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random resets and a forced frame-counter wrap, scored against a cycle-count model on a shrunk raster.
module tb_vga_timing_gen;
    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 24, VF = 2, VS = 2, VB = 3;
    localparam int PD = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank, hs, vs, blank_d, hs_d, vs_d, fs, vbs;
        logic [15:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   t, base, tests, errs;
    obs_t q[$];
    obs_t e, g;

    vga_timing_gen_if vif ();
    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_DELAY(PD)
    ) dut (
        .vga_clk (clk),
        .reset   (rst),
        .vga     (vif)
    );

    always #5 clk = ~clk;

    // {blank, hs, vs} at raster position n cycles into a frame sequence
    function automatic logic [2:0] sigs(input int n);
        int x = n % HT;
        int y = (n / HT) % VT;
        return {x < HV && y < VV, !(x >= HV + HF && x < HV + HF + HS), !(y >= VV + VF && y < VV + VF + VS)};
    endfunction

    function automatic obs_t model(input int n, input int b);
        obs_t m;
        m.x = 10'(n % HT);
        m.y = 10'((n / HT) % VT);
        {m.blank, m.hs, m.vs} = sigs(n);
        {m.blank_d, m.hs_d, m.vs_d} = (n >= PD) ? sigs(n - PD) : 3'b011;
        m.fs  = (n % FT) == 0;
        m.vbs = (n % HT) == 0 && ((n / HT) % VT) == VV;
        m.fc  = 16'(b + n / FT);
        return m;
    endfunction

    task automatic step(input logic r, input logic frc);
        @(posedge clk);
        #1;
        t = rst ? 0 : t + 1;
        rst = r;
        if (r) t = 0;
        if (frc) begin
            force dut.fc_q = 16'hFFFF;
            #1;
            release dut.fc_q;
            base = 65535 - t / FT;
        end
        q.push_back(model(t, base));
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            g = {vif.DrawX, vif.DrawY, vif.blank, vif.hs, vif.vs, vif.blank_d, vif.hs_d, vif.vs_d,
                 vif.frame_start, vif.vblank_start, vif.frame_count};
            tests++;
            if (g !== e) begin
                errs++;
                $display("FAIL raster @%0t got x=%0d y=%0d bhv=%b%b%b bhv_d=%b%b%b fs=%b vb=%b fc=%h, want x=%0d y=%0d bhv=%b%b%b bhv_d=%b%b%b fs=%b vb=%b fc=%h",
                         $time, g.x, g.y, g.blank, g.hs, g.vs, g.blank_d, g.hs_d, g.vs_d, g.fs, g.vbs, g.fc,
                         e.x, e.y, e.blank, e.hs, e.vs, e.blank_d, e.hs_d, e.vs_d, e.fs, e.vbs, e.fc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        t = 0;
        base = 0;
        tests = 0;
        errs = 0;
        repeat (5) step(1'b1, 1'b0);
        repeat (2 * FT + 100) step(1'b0, 1'b0);
        repeat (3) begin
            repeat ($urandom_range(50, FT)) step(1'b0, 1'b0);
            repeat ($urandom_range(1, 4)) step(1'b1, 1'b0);
        end
        repeat ($urandom_range(10, 300)) step(1'b0, 1'b0);
        while (t % FT != FT - 40) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (FT + 200) step(1'b0, 1'b0);
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
